// File: rtl/dem_0_99_up.sv
// Two-digit BCD up-counter (00..TOP) with built-in tick prescaler, load, pause,
// terminal-count pulse and a multiplexed active-low seven-segment driver.
module dem_0_99_up #(
   parameter int TICK_DIV = 50000000,
   parameter int SCAN_DIV = 25000,
   parameter int TOP      = 99
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   input  logic [3:0] load_tens,
   input  logic [3:0] load_ones,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic       tick,
   output logic       tc,
   output logic [6:0] seg,
   output logic [1:0] an
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int SW = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [3:0]    TOP_TENS   = 4'(TOP / 10);
   localparam logic [3:0]    TOP_ONES   = 4'(TOP % 10);

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = 7'b1111111;
      endcase
   endfunction

   function automatic logic [3:0] clamp9(input logic [3:0] d);
      if (d > 4'd9) begin
         clamp9 = 4'd9;
      end else begin
         clamp9 = d;
      end
   endfunction

   logic [3:0]    tens_r, ones_r, tens_nx_s, ones_nx_s, ld_tens_s, ld_ones_s;
   logic [PW-1:0] presc_r, presc_nx_s;
   logic          tick_r, tc_r, tick_nx_s, tc_nx_s;
   logic [SW-1:0] scan_r, scan_nx_s;
   logic          sel_r, sel_nx_s;
   logic [1:0]    an_r, an_nx_s;
   logic [6:0]    seg_r, seg_nx_s;

   // Next count state: load beats step; BCD compare is valid once digits are clamped.
   always_comb begin
      tens_nx_s  = tens_r;
      ones_nx_s  = ones_r;
      presc_nx_s = presc_r;
      tick_nx_s  = 1'b0;
      tc_nx_s    = 1'b0;
      ld_tens_s  = clamp9(load_tens);
      ld_ones_s  = clamp9(load_ones);
      if (load) begin
         if ({ld_tens_s, ld_ones_s} > {TOP_TENS, TOP_ONES}) begin
            tens_nx_s = TOP_TENS;
            ones_nx_s = TOP_ONES;
         end else begin
            tens_nx_s = ld_tens_s;
            ones_nx_s = ld_ones_s;
         end
         presc_nx_s = {PW{1'b0}};
      end else if (enable) begin
         if (presc_r == PRESC_LAST) begin
            presc_nx_s = {PW{1'b0}};
            tick_nx_s  = 1'b1;
            if ({tens_r, ones_r} == {TOP_TENS, TOP_ONES}) begin
               tens_nx_s = 4'd0;
               ones_nx_s = 4'd0;
               tc_nx_s   = 1'b1;
            end else if (ones_r == 4'd9) begin
               ones_nx_s = 4'd0;
               tens_nx_s = tens_r + 4'd1;
            end else begin
               ones_nx_s = ones_r + 4'd1;
            end
         end else begin
            presc_nx_s = presc_r + PW'(1'b1);
         end
      end else begin
         presc_nx_s = presc_r;
      end
   end

   // Next display state; seg uses next digits so it always matches tens/ones.
   always_comb begin
      scan_nx_s = scan_r;
      sel_nx_s  = sel_r;
      an_nx_s   = 2'b10;
      seg_nx_s  = 7'b1111111;
      if (scan_r == SCAN_LAST) begin
         scan_nx_s = {SW{1'b0}};
         sel_nx_s  = ~sel_r;
      end else begin
         scan_nx_s = scan_r + SW'(1'b1);
      end
      if (sel_nx_s) begin
         an_nx_s  = 2'b01;
         seg_nx_s = glyph(tens_nx_s);
      end else begin
         an_nx_s  = 2'b10;
         seg_nx_s = glyph(ones_nx_s);
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         tens_r  <= 4'd0;
         ones_r  <= 4'd0;
         presc_r <= {PW{1'b0}};
         tick_r  <= 1'b0;
         tc_r    <= 1'b0;
         scan_r  <= {SW{1'b0}};
         sel_r   <= 1'b0;
         an_r    <= 2'b10;
         seg_r   <= 7'b1000000;
      end else begin
         tens_r  <= tens_nx_s;
         ones_r  <= ones_nx_s;
         presc_r <= presc_nx_s;
         tick_r  <= tick_nx_s;
         tc_r    <= tc_nx_s;
         scan_r  <= scan_nx_s;
         sel_r   <= sel_nx_s;
         an_r    <= an_nx_s;
         seg_r   <= seg_nx_s;
      end
   end

   assign tens = tens_r;
   assign ones = ones_r;
   assign tick = tick_r;
   assign tc   = tc_r;
   assign seg  = seg_r;
   assign an   = an_r;

endmodule

// File: tb/tb_dem_0_99_up.sv
// Bench for dem_0_99_up: two instances (TOP=99 and TOP=23) driven in parallel,
// checked each cycle against an integer model plus hand-computed literals.
module tb_dem_0_99_up;
   localparam int TD = 4;
   localparam int SD = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset = 1'b1, enable = 1'b0, load = 1'b0;
   logic [3:0] load_tens = 4'd0, load_ones = 4'd0;
   logic [3:0] tens0, ones0, tens1, ones1;
   logic       tick0, tc0, tick1, tc1;
   logic [6:0] seg0, seg1;
   logic [1:0] an0, an1;

   dem_0_99_up #(.TICK_DIV(TD), .SCAN_DIV(SD), .TOP(99)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .load_tens(load_tens), .load_ones(load_ones),
      .tens(tens0), .ones(ones0), .tick(tick0), .tc(tc0), .seg(seg0), .an(an0));

   dem_0_99_up #(.TICK_DIV(TD), .SCAN_DIV(SD), .TOP(23)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .load(load),
      .load_tens(load_tens), .load_ones(load_ones),
      .tens(tens1), .ones(ones1), .tick(tick1), .tc(tc1), .seg(seg1), .an(an1));

   int errors = 0;
   int checks = 0;
   bit check_en = 1'b0;

   logic [6:0] glyph_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

   int tops [2] = '{99, 23};
   int m_cnt [2];
   int m_ph [2];
   bit m_tick [2];
   bit m_tc [2];
   int m_n = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Model: count as a plain integer 0..TOP, phase as cycles since last step.
   always @(posedge clk) begin
      if (reset) begin
         m_n = 0;
         for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_ph[i] = 0; m_tick[i] = 1'b0; m_tc[i] = 1'b0;
         end
      end else begin
         m_n++;
         for (int i = 0; i < 2; i++) begin
            int lt, lo, v;
            m_tick[i] = 1'b0;
            m_tc[i]   = 1'b0;
            if (load) begin
               lt = (int'(load_tens) > 9) ? 9 : int'(load_tens);
               lo = (int'(load_ones) > 9) ? 9 : int'(load_ones);
               v  = lt * 10 + lo;
               m_cnt[i] = (v > tops[i]) ? tops[i] : v;
               m_ph[i]  = 0;
            end else if (enable) begin
               if (m_ph[i] == TD - 1) begin
                  m_ph[i]   = 0;
                  m_tick[i] = 1'b1;
                  m_tc[i]   = (m_cnt[i] == tops[i]);
                  m_cnt[i]  = (m_cnt[i] == tops[i]) ? 0 : m_cnt[i] + 1;
               end else begin
                  m_ph[i]++;
               end
            end
         end
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (check_en) begin
         for (int i = 0; i < 2; i++) begin
            logic [1:0] exp_an;
            logic [6:0] exp_seg;
            exp_an  = (((m_n / SD) % 2) == 1) ? 2'b01 : 2'b10;
            exp_seg = (exp_an == 2'b01) ? glyph_tab[m_cnt[i] / 10] : glyph_tab[m_cnt[i] % 10];
            chk($sformatf("dut%0d tens", i), (i == 0) ? tens0 : tens1, m_cnt[i] / 10);
            chk($sformatf("dut%0d ones", i), (i == 0) ? ones0 : ones1, m_cnt[i] % 10);
            chk($sformatf("dut%0d tick", i), (i == 0) ? tick0 : tick1, m_tick[i]);
            chk($sformatf("dut%0d tc", i), (i == 0) ? tc0 : tc1, m_tc[i]);
            chk($sformatf("dut%0d an", i), (i == 0) ? an0 : an1, exp_an);
            chk($sformatf("dut%0d seg", i), (i == 0) ? seg0 : seg1, exp_seg);
         end
      end
   end

   task automatic drive(input logic r, input logic e, input logic l,
                        input logic [3:0] lt, input logic [3:0] lo);
      reset = r; enable = e; load = l; load_tens = lt; load_ones = lo;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int ticks, tcs, changes, an_zero;
      logic [1:0] prev_an;

      // Reset and free run
      drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0);
      check_en = 1'b1;
      chk("reset tens", tens0, 0);
      chk("reset ones", ones0, 0);
      chk("reset an", an0, 2'b10);
      chk("reset seg", seg0, 7'b1000000);
      chk("reset tick", tick0, 0);
      chk("reset tc", tc0, 0);
      ticks = 0; tcs = 0;
      for (int k = 0; k < 16; k++) begin
         drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
         ticks += int'(tick0);
         tcs   += int'(tc0);
      end
      chk("run ticks", ticks, 4);
      chk("run tc", tcs, 0);
      chk("run ones", ones0, 4);
      chk("run last tick", tick0, 1);

      // Rollover and wrap
      drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd9);
      chk("load09 ones", ones0, 9);
      chk("load09 tick", tick0, 0);
      repeat (4) drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("carry tens", tens0, 1);
      chk("carry ones", ones0, 0);
      chk("carry tens top23", tens1, 1);
      drive(1'b0, 1'b1, 1'b1, 4'd9, 4'd9);
      chk("load99 tens", tens0, 9);
      chk("load99 top23 ones", ones1, 3);
      repeat (3) drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("pre-wrap tc", tc0, 0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("wrap tens", tens0, 0);
      chk("wrap ones", ones0, 0);
      chk("wrap tc", tc0, 1);
      chk("wrap tick", tick0, 1);
      chk("wrap tc top23", tc1, 1);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("tc one cycle", tc0, 0);

      // TOP=23 terminal count and clamping
      drive(1'b0, 1'b1, 1'b1, 4'd2, 4'd3);
      repeat (4) drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("top23 wrap ones", ones1, 0);
      chk("top23 wrap tc", tc1, 1);
      chk("top99 at 24", ones0, 4);
      chk("top99 no tc", tc0, 0);
      drive(1'b0, 1'b1, 1'b1, 4'd5, 4'd7);
      chk("load57 top23 tens", tens1, 2);
      chk("load57 top23 ones", ones1, 3);
      chk("load57 top99 tens", tens0, 5);
      drive(1'b0, 1'b1, 1'b1, 4'd12, 4'd3);
      chk("load12_3 top23", {tens1, ones1}, 8'h23);
      chk("load12_3 top99", {tens0, ones0}, 8'h93);

      // Pause keeps prescaler phase
      repeat (2) drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      ticks = 0; tcs = 0;
      repeat (10) begin
         drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
         ticks += int'(tick0);
         tcs   += int'(tc1);
      end
      chk("pause ticks", ticks, 0);
      chk("pause tc", tcs, 0);
      chk("pause held", {tens0, ones0}, 8'h93);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("resume 1st tick", tick0, 0);
      drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      chk("resume 2nd tick", tick0, 1);
      chk("resume count", {tens0, ones0}, 8'h94);

      // Load on a step edge, then reset with load
      repeat (3) drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      drive(1'b0, 1'b1, 1'b1, 4'd4, 4'd2);
      chk("load-step count", {tens0, ones0}, 8'h42);
      chk("load-step tick", tick0, 0);
      chk("load-step top23", {tens1, ones1}, 8'h23);
      drive(1'b1, 1'b1, 1'b1, 4'd4, 4'd2);
      chk("reset-load count", {tens0, ones0}, 8'h00);
      chk("reset-load tick", tick0, 0);
      chk("reset-load an", an0, 2'b10);
      chk("reset-load seg", seg0, 7'b1000000);

      // Display scan holding 37
      drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd7);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      chk("scan ones an", an0, 2'b10);
      chk("scan ones seg", seg0, 7'b1111000);
      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      chk("scan tens an", an0, 2'b01);
      chk("scan tens seg", seg0, 7'b0110000);
      chk("scan tens seg top23", seg1, 7'b0100100);
      prev_an = an0; changes = 0; an_zero = 0;
      repeat (12) begin
         drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
         if (an0 != prev_an) changes++;
         if (an0 == 2'b00) an_zero++;
         prev_an = an0;
      end
      chk("scan toggles", changes, 4);
      chk("scan both low", an_zero, 0);

      drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      check_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
